// File: rtl/led_blink_array.sv
// Multi-channel LED driver: off / on / blink (tick-based) / PWM dim per channel.
// Define LED_BLINK_SYNC_EN to pass mode through a two-flop synchronizer (3-clk mode-to-led latency).
module led_blink_array #(
  parameter int N_CH    = 3,
  parameter int CLK_HZ  = 48000000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 16,
  parameter int PWM_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH*CNT_W-1:0] half_period,
  input  logic [N_CH*PWM_W-1:0] duty,
  output logic [N_CH-1:0]       led,
  output logic                  tick
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_e;

  logic [PS_W-1:0]   ps_cnt;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [2*N_CH-1:0] mode_use;

`ifdef LED_BLINK_SYNC_EN
  logic [2*N_CH-1:0] mode_meta;
  logic [2*N_CH-1:0] mode_sync;

  // Reset value 0 puts every channel in off mode until the switches have settled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_meta <= '0;
      mode_sync <= '0;
    end else begin
      mode_meta <= mode;
      mode_sync <= mode_meta;
    end
  end

  assign mode_use = mode_sync;
`else
  assign mode_use = mode;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_cnt <= '0;
      tick   <= 1'b0;
    end else begin
      tick   <= (ps_cnt == PS_LAST);
      ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    mode_e            ch_mode;
    logic [CNT_W-1:0] hp;
    logic [CNT_W-1:0] hp_last;
    logic [CNT_W-1:0] bcnt;
    logic [PWM_W-1:0] ch_duty;
    logic             phase;
    logic             led_q;

    assign ch_mode = mode_e'(mode_use[2*c +: 2]);
    assign hp      = half_period[c*CNT_W +: CNT_W];
    assign ch_duty = duty[c*PWM_W +: PWM_W];

    // A zero half-period behaves as one tick, so the last count is clamped at 0.
    assign hp_last = (hp == '0) ? '0 : hp - CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        bcnt  <= '0;
        phase <= 1'b0;
        led_q <= 1'b0;
      end else begin
        case (ch_mode)
          MODE_BLINK: begin
            led_q <= phase;
            if (tick) begin
              // >= compare: a lowered half-period toggles on the next tick instead of wrapping.
              if (bcnt >= hp_last) begin
                bcnt  <= '0;
                phase <= ~phase;
              end else begin
                bcnt <= bcnt + CNT_W'(1);
              end
            end
          end
          MODE_PWM: begin
            led_q <= (pwm_cnt < ch_duty);
            bcnt  <= '0;
            phase <= 1'b0;
          end
          MODE_ON: begin
            led_q <= 1'b1;
            bcnt  <= '0;
            phase <= 1'b0;
          end
          default: begin
            led_q <= 1'b0;
            bcnt  <= '0;
            phase <= 1'b0;
          end
        endcase
      end
    end

    assign led[c] = led_q;
  end

endmodule

// File: tb/tb_led_blink_array.sv
// Self-checking bench for led_blink_array: cycle-level reference model plus directed literal checks.
// Honors LED_BLINK_SYNC_EN (3-clk mode latency) when defined.
module tb_led_blink_array;

  localparam int N     = 3;
  localparam int CNT_W = 8;
  localparam int PWM_W = 4;
  localparam int DIV   = 10;
  localparam int PWM_N = 16;
`ifdef LED_BLINK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic [2*N-1:0]     mode;
  logic [N*CNT_W-1:0] half_period;
  logic [N*PWM_W-1:0] duty;
  logic [N-1:0]       led;
  logic               tick;

  int n_cmp = 0;
  int n_bad = 0;

  led_blink_array #(
    .N_CH(N), .CLK_HZ(100), .TICK_HZ(10), .CNT_W(CNT_W), .PWM_W(PWM_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .half_period(half_period),
    .duty(duty), .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // k counts clock edges since reset release; tick and PWM count follow from k directly.
  int unsigned k = 0;
  int          s[N];
  bit          p[N];
  logic [1:0]  hist1[N];
  logic [1:0]  hist2[N];
  logic [N-1:0] m_led = '0;
  logic        m_tick = 1'b0;
  int unsigned kp;
  bit          tick_old;
  int          pwm_old;
  int          hp;
  logic [1:0]  md;

  initial begin
    for (int c = 0; c < N; c++) begin
      s[c] = 0; p[c] = 0; hist1[c] = 2'b00; hist2[c] = 2'b00;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k = 0; m_led = '0; m_tick = 1'b0;
      for (int c = 0; c < N; c++) begin
        s[c] = 0; p[c] = 0; hist1[c] = 2'b00; hist2[c] = 2'b00;
      end
    end else begin
      kp       = k;
      k        = k + 1;
      tick_old = (kp > 0) && (kp % DIV == 0);
      m_tick   = (k % DIV == 0);
      pwm_old  = int'(kp % PWM_N);
      for (int c = 0; c < N; c++) begin
`ifdef LED_BLINK_SYNC_EN
        md       = hist2[c];
        hist2[c] = hist1[c];
        hist1[c] = mode[2*c +: 2];
`else
        md = mode[2*c +: 2];
`endif
        case (md)
          2'b00: begin m_led[c] = 1'b0; s[c] = 0; p[c] = 0; end
          2'b01: begin m_led[c] = 1'b1; s[c] = 0; p[c] = 0; end
          2'b10: begin
            m_led[c] = p[c];
            if (tick_old) begin
              hp = int'(half_period[c*CNT_W +: CNT_W]);
              if (hp < 1) hp = 1;
              if (s[c] + 1 >= hp) begin s[c] = 0; p[c] = !p[c]; end
              else s[c] = s[c] + 1;
            end
          end
          default: begin
            m_led[c] = (pwm_old < int'(duty[c*PWM_W +: PWM_W]));
            s[c] = 0; p[c] = 0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check("led_vs_model", int'(led), int'(m_led));
    check("tick_vs_model", int'(tick), int'(m_tick));
  end

  // ---------------- helpers ----------------
  task automatic set_mode(input int c, input logic [1:0] m);
    mode[2*c +: 2] = m;
  endtask

  task automatic wait_led(input int c, input logic lvl, input string nm);
    int n = 0;
    while (led[c] !== lvl && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check({nm, "_timeout"}, int'(led[c]), int'(lvl));
  endtask

  task automatic run_len(input int c, input logic lvl, output int n);
    n = 0;
    while (led[c] == lvl && n < 500) begin @(negedge clk); n++; end
  endtask

  task automatic wait_tick(input string nm);
    int n = 0;
    while (tick !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check({nm, "_tick_timeout"}, int'(tick), 1);
  endtask

  task automatic ticks_to_rise(input int c, output int t);
    t = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (led[c]) break;
      if (tick) t++;
    end
    if (!led[c]) t = -1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    bit got;
    int ch;

    mode = {N{2'b01}};
    half_period = '0;
    duty = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", int'(led), 0);
    check("reset_tick", int'(tick), 0);
    reset_n = 1'b1;

    cnt = 0; got = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (tick) begin cnt = i; got = 1; end
    end
    check("first_tick_edge", cnt, DIV);
    @(posedge clk); #1;
    check("tick_width", int'(tick), 0);
    cnt = 0; got = 0;
    for (int i = 2; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (tick) begin cnt = i; got = 1; end
    end
    check("tick_period", cnt, DIV);

    // static modes
    @(negedge clk);
    mode = '0;
    repeat (LAT + 2) @(negedge clk);
    set_mode(0, 2'b01);
    set_mode(1, 2'b00);
    cnt = 0; got = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(posedge clk); #1;
      if (led[0]) begin cnt = i; got = 1; end
    end
    check("mode_latency", cnt, LAT);
    cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (led[0] && !led[1]) cnt++;
    end
    check("static_1000", cnt, 1000);

    // blink, half_period = 3 -> 30 clk runs
    half_period[2*CNT_W +: CNT_W] = 8'd3;
    set_mode(2, 2'b10);
    wait_led(2, 1'b1, "blink3_rise");
    run_len(2, 1'b1, cnt);
    check("blink3_high_run", cnt, 30);
    run_len(2, 1'b0, cnt);
    check("blink3_low_run", cnt, 30);

    // half_period = 0 behaves as 1 -> 10 clk runs
    half_period[2*CNT_W +: CNT_W] = 8'd0;
    wait_led(2, 1'b0, "blink0_fall");
    wait_led(2, 1'b1, "blink0_rise");
    run_len(2, 1'b1, cnt);
    check("blink0_high_run", cnt, 10);
    run_len(2, 1'b0, cnt);
    check("blink0_low_run", cnt, 10);

    // PWM
    set_mode(2, 2'b00);
    set_mode(0, 2'b11);
    duty[0 +: PWM_W] = 4'd4;
    repeat (LAT + 2) @(negedge clk);
    cnt = 0;
    repeat (PWM_N) begin @(negedge clk); if (led[0]) cnt++; end
    check("pwm_duty4", cnt, 4);
    duty[0 +: PWM_W] = 4'd0;
    repeat (3) @(negedge clk);
    cnt = 0;
    repeat (2 * PWM_N) begin @(negedge clk); if (led[0]) cnt++; end
    check("pwm_duty0", cnt, 0);
    duty[0 +: PWM_W] = 4'd15;
    repeat (3) @(negedge clk);
    cnt = 0;
    repeat (PWM_N) begin @(negedge clk); if (led[0]) cnt++; end
    check("pwm_duty15", cnt, 15);

    // mid-count half-period change
    set_mode(0, 2'b00);
    half_period[2*CNT_W +: CNT_W] = 8'd5;
    repeat (LAT + 2) @(negedge clk);
    wait_tick("mid_align");
    @(negedge clk);
    set_mode(2, 2'b10);
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 3; i++) begin
      @(negedge clk);
      if (tick) cnt++;
    end
    @(negedge clk);
    check("mid_still_low", int'(led[2]), 0);
    half_period[2*CNT_W +: CNT_W] = 8'd2;
    ticks_to_rise(2, cnt);
    check("mid_ticks_to_toggle", cnt, 1);

    // leave and re-enter blink
    set_mode(2, 2'b00);
    repeat (LAT + 2) @(negedge clk);
    check("reenter_off_low", int'(led[2]), 0);
    wait_tick("reenter_align");
    @(negedge clk);
    set_mode(2, 2'b10);
    ticks_to_rise(2, cnt);
    check("reenter_ticks_to_rise", cnt, 2);

    // async reset between clock edges
    wait_led(2, 1'b1, "async_pre");
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_led", int'(led), 0);
    check("async_tick", int'(tick), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ticks_to_rise(2, cnt);
    check("post_reset_ticks_to_rise", cnt, 2);

    // randomized traffic against the model
    repeat (3000) begin
      @(negedge clk);
      ch = $urandom_range(0, N - 1);
      if ($urandom_range(0, 15) == 0) set_mode(ch, 2'($urandom_range(0, 3)));
      ch = $urandom_range(0, N - 1);
      if ($urandom_range(0, 63) == 0) half_period[ch*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 4));
      ch = $urandom_range(0, N - 1);
      if ($urandom_range(0, 31) == 0) duty[ch*PWM_W +: PWM_W] = PWM_W'($urandom_range(0, 15));
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
